// File: rtl/main_memory.sv
// Word-addressed 32-bit memory with a fixed-latency read pipeline and a sticky bad-address flag.
// Optional same-edge write-to-read bypass is compiled in when MAIN_MEMORY_BYPASS_EN is defined.
module main_memory #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_enable,
    input  logic [31:0] read_address,
    input  logic        write_enable,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic        error_clear,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        addr_error
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic          rd_good;
    logic          wr_good;
    logic [31:0]   rd_word;

    logic [READ_LATENCY-1:0] pipe_v;
    logic [31:0]             pipe_d [READ_LATENCY];

    // A good address is word aligned and has no bits set above the array span.
    assign rd_idx  = read_address[AW+1:2];
    assign wr_idx  = write_address[AW+1:2];
    assign rd_good = (read_address[1:0] == 2'b00) && (read_address[31:AW+2] == '0);
    assign wr_good = (write_address[1:0] == 2'b00) && (write_address[31:AW+2] == '0);

    always_comb begin
        rd_word = mem[rd_idx];
`ifdef MAIN_MEMORY_BYPASS_EN
        if (write_enable && wr_good && (wr_idx == rd_idx)) begin
            rd_word = write_data;
        end
`endif
        if (!rd_good) begin
            rd_word = '0;
        end
    end

    // Array contents are deliberately not reset; writes are ignored while in reset.
    always_ff @(posedge clk) begin
        if (rst_n && write_enable && wr_good) begin
            mem[wr_idx] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        pipe_d[0] <= rd_word;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v     <= '0;
            read_valid <= 1'b0;
            read_data  <= '0;
            addr_error <= 1'b0;
        end else begin
            pipe_v[0] <= read_enable;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
            end
            read_valid <= pipe_v[READ_LATENCY-1];
            if (pipe_v[READ_LATENCY-1]) begin
                read_data <= pipe_d[READ_LATENCY-1];
            end
            // A new bad access on the same edge wins over error_clear.
            if ((read_enable && !rd_good) || (write_enable && !wr_good)) begin
                addr_error <= 1'b1;
            end else if (error_clear) begin
                addr_error <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: directed vector table, multi-cycle sequences and randomized traffic
// checked every cycle against a queue-based reference model.
module tb_main_memory;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read_enable = 1'b0;
    logic [31:0] read_address = '0;
    logic        write_enable = 1'b0;
    logic [31:0] write_address = '0;
    logic [31:0] write_data = '0;
    logic        error_clear = 1'b0;
    logic [31:0] read_data;
    logic        read_valid;
    logic        addr_error;

    always #5 clk = ~clk;

    main_memory #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_enable(read_enable), .read_address(read_address),
        .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
        .error_clear(error_clear),
        .read_data(read_data), .read_valid(read_valid), .addr_error(addr_error)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cycle = 0;

    logic [31:0] mem_m [int];
    logic [31:0] exp_q[$];
    int          due_q[$];
    logic [31:0] got_q[$];
    logic        err_m = 1'b0;
    logic [31:0] last_m = '0;

    typedef struct {
        logic        re;
        logic [31:0] ra;
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        clr;
        logic        exp_rv;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t vt[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(4 * DEPTH));
    endfunction

    task automatic drive(input logic re, input logic [31:0] ra, input logic we,
                         input logic [31:0] wa, input logic [31:0] wd, input logic clr);
        read_enable = re; read_address = ra;
        write_enable = we; write_address = wa; write_data = wd;
        error_clear = clr;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // One clock: update the model from the inputs seen at the edge, then compare just after it.
    task automatic tick();
        logic [31:0] v;
        @(posedge clk);
        cycle++;
        if (rst_n) begin
            if (read_enable) begin
                if (is_bad(read_address)) v = '0;
                else begin
                    v = mem_m[int'(read_address / 4)];
`ifdef MAIN_MEMORY_BYPASS_EN
                    if (write_enable && !is_bad(write_address) && write_address == read_address)
                        v = write_data;
`endif
                end
                exp_q.push_back(v);
                due_q.push_back(cycle + LAT);
            end
            if (write_enable && !is_bad(write_address))
                mem_m[int'(write_address / 4)] = write_data;
            if ((read_enable && is_bad(read_address)) || (write_enable && is_bad(write_address)))
                err_m = 1'b1;
            else if (error_clear)
                err_m = 1'b0;
        end
        #1;
        if (due_q.size() > 0 && due_q[0] == cycle) begin
            check("read_valid", 32'(read_valid), 32'd1);
            check("read_data", read_data, exp_q[0]);
            last_m = exp_q[0];
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end else begin
            check("idle_valid", 32'(read_valid), 32'd0);
            check("hold_data", read_data, last_m);
        end
        check("addr_error", 32'(addr_error), 32'(err_m));
        if (read_valid) got_q.push_back(read_data);
    endtask

    task automatic enter_reset();
        rst_n = 1'b0;
        exp_q.delete();
        due_q.delete();
        err_m = 1'b0;
        last_m = '0;
        #1;
        check("rst_data", read_data, 32'd0);
        check("rst_valid", 32'(read_valid), 32'd0);
        check("rst_error", 32'(addr_error), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) != 0) return 32'($urandom_range(0, 63) * 4);
        if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
        return 32'(4 * DEPTH + $urandom_range(0, 1000) * 4);
    endfunction

    initial begin
        vt[0]  = '{1'b0, 32'h0,    1'b1, 32'h10,   32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0};
        vt[1]  = '{1'b1, 32'h10,   1'b0, 32'h0,    32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 32'h12,   1'b0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
        vt[3]  = '{1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        vt[4]  = '{1'b1, 32'h1000, 1'b0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
        vt[5]  = '{1'b0, 32'h0,    1'b1, 32'h1001, 32'h77,       1'b1, 1'b0, 32'h0,        1'b1};
        vt[6]  = '{1'b0, 32'h0,    1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        vt[7]  = '{1'b0, 32'h0,    1'b1, 32'h20,   32'h5,        1'b0, 1'b0, 32'h0,        1'b0};
`ifdef MAIN_MEMORY_BYPASS_EN
        vt[8]  = '{1'b1, 32'h20,   1'b1, 32'h20,   32'hA,        1'b0, 1'b1, 32'hA,        1'b0};
`else
        vt[8]  = '{1'b1, 32'h20,   1'b1, 32'h20,   32'hA,        1'b0, 1'b1, 32'h5,        1'b0};
`endif
        vt[9]  = '{1'b1, 32'h20,   1'b0, 32'h0,    32'h0,        1'b0, 1'b1, 32'hA,        1'b0};
        vt[10] = '{1'b0, 32'h0,    1'b1, 32'hFFC,  32'h12345678, 1'b0, 1'b0, 32'h0,        1'b0};
        vt[11] = '{1'b1, 32'hFFC,  1'b0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h12345678, 1'b0};

        // Power-on reset, then prefill the words used by the random phase.
        enter_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int w = 0; w < 64; w++) begin
            drive(1'b0, '0, 1'b1, 32'(w * 4), $urandom, 1'b0);
            tick();
        end
        idle();
        tick();

        // Directed vectors: one op, then look at the outputs LAT edges after its issue edge.
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].re, vt[i].ra, vt[i].we, vt[i].wa, vt[i].wd, vt[i].clr);
            tick();
            idle();
            repeat (LAT) tick();
            check($sformatf("vec%0d_valid", i), 32'(read_valid), 32'(vt[i].exp_rv));
            if (vt[i].exp_rv) check($sformatf("vec%0d_data", i), read_data, vt[i].exp_rd);
            check($sformatf("vec%0d_error", i), 32'(addr_error), 32'(vt[i].exp_err));
        end

        // Back-to-back reads return in issue order on consecutive cycles.
        for (int w = 0; w < 3; w++) begin
            drive(1'b0, '0, 1'b1, 32'(w * 4), 32'(w + 1), 1'b0);
            tick();
        end
        got_q.delete();
        for (int w = 0; w < 3; w++) begin
            drive(1'b1, 32'(w * 4), 1'b0, '0, '0, 1'b0);
            tick();
        end
        idle();
        repeat (LAT) tick();
        check("b2b_count", 32'(got_q.size()), 32'd3);
        for (int w = 0; w < 3 && w < got_q.size(); w++)
            check($sformatf("b2b_data%0d", w), got_q[w], 32'(w + 1));

        // Reset one cycle after a read issue: the read is dropped, the array survives.
        drive(1'b1, 32'h10, 1'b0, '0, '0, 1'b0);
        tick();
        enter_reset();
        drive(1'b1, 32'h13, 1'b1, 32'h10, 32'h0BAD0BAD, 1'b1);
        repeat (2) tick();
        idle();
        rst_n = 1'b1;
        got_q.delete();
        repeat (LAT + 2) tick();
        check("rst_drop_count", 32'(got_q.size()), 32'd0);
        drive(1'b1, 32'h10, 1'b0, '0, '0, 1'b0);
        tick();
        idle();
        repeat (LAT) tick();
        check("rst_keep_valid", 32'(read_valid), 32'd1);
        check("rst_keep_data", read_data, 32'hDEADBEEF);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic [31:0] ra;
            ra = rand_addr();
            drive(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? ra : rand_addr(), $urandom,
                  1'($urandom_range(0, 7) == 0));
            tick();
        end
        idle();
        repeat (LAT + 1) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
